// File: rtl/mux_n_req_l2.sv
// L2 crossbar request multiplexer: round-robin merge of N_CH request channels
// onto one bank port, with an optional single-entry output register.
module mux_n_req_l2 #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ID_WIDTH   = 20,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TAG_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned OUT_REG    = 0,
  localparam int unsigned PTR_W     = $clog2(N_CH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CH-1:0]                 data_req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_CH-1:0]                 data_wen_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_CH-1:0][TAG_WIDTH-1:0]  data_wtag_i,
  input  logic [N_CH-1:0][BE_WIDTH-1:0]   data_be_i,
  input  logic [N_CH-1:0][ID_WIDTH-1:0]   data_ID_i,
  output logic [N_CH-1:0]                 data_gnt_o,
  output logic                            data_req_o,
  output logic [ADDR_WIDTH-1:0]           data_add_o,
  output logic                            data_wen_o,
  output logic [DATA_WIDTH-1:0]           data_wdata_o,
  output logic [TAG_WIDTH-1:0]            data_wtag_o,
  output logic [BE_WIDTH-1:0]             data_be_o,
  output logic [ID_WIDTH-1:0]             data_ID_o,
  input  logic                            data_gnt_i
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [TAG_WIDTH-1:0]  wtag;
    logic [BE_WIDTH-1:0]   be;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  int unsigned      scan;
  logic [PTR_W-1:0] scan_idx;
  logic             upstream_rdy;
  logic             accept;
  req_t             sel_req;
  req_t             out_req;

  // Scan upward from ptr with wrap at N_CH-1; first requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= N_CH) scan = scan - N_CH;
      scan_idx = PTR_W'(scan);
      if (!win_valid && data_req_i[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    if (win_valid) begin
      sel_req.add   = data_add_i[win_idx];
      sel_req.wen   = data_wen_i[win_idx];
      sel_req.wdata = data_wdata_i[win_idx];
      sel_req.wtag  = data_wtag_i[win_idx];
      sel_req.be    = data_be_i[win_idx];
      sel_req.id    = data_ID_i[win_idx];
    end
  end

  always_comb begin
    data_gnt_o = '0;
    if (accept) data_gnt_o[win_idx] = 1'b1;
  end

  // Explicit wrap so a non-power-of-2 N_CH never lets ptr reach N_CH.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (win_idx == PTR_W'(N_CH - 1)) ptr_d = '0;
      else                             ptr_d = win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  if (OUT_REG == 0) begin : g_comb
    assign upstream_rdy = data_gnt_i;
    assign accept       = win_valid & upstream_rdy;
    assign data_req_o   = |data_req_i;
    assign out_req      = sel_req;
  end else begin : g_reg
    logic buf_valid_q, buf_valid_d;
    req_t buf_q, buf_d;

    assign upstream_rdy = ~buf_valid_q | data_gnt_i;
    // A grant issued under reset could never be captured, so suppress it.
    assign accept       = win_valid & upstream_rdy & rst_n;

    always_comb begin
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;
      if (accept) begin
        buf_valid_d = 1'b1;
        buf_d       = sel_req;
      end else if (data_gnt_i && buf_valid_q) begin
        buf_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_valid_q <= 1'b0;
        buf_q       <= '0;
      end else begin
        buf_valid_q <= buf_valid_d;
        buf_q       <= buf_d;
      end
    end

    assign data_req_o = buf_valid_q;
    assign out_req    = buf_q;
  end

  assign data_add_o   = out_req.add;
  assign data_wen_o   = out_req.wen;
  assign data_wdata_o = out_req.wdata;
  assign data_wtag_o  = out_req.wtag;
  assign data_be_o    = out_req.be;
  assign data_ID_o    = out_req.id;

endmodule

// File: tb/tb_mux_n_req_l2.sv
// Bench for mux_n_req_l2: three instances (N=4 comb, N=4 registered, N=3 comb)
// checked against a distance-based round-robin reference model.
module tb_mux_n_req_l2;
  localparam int AW = 32, DW = 64, TW = 8, BW = 8, IW = 20;
  localparam int FW = AW + 1 + DW + TW + BW + IW;

  logic clk = 1'b0;
  logic rst_n;
  logic gnt_i;
  always #5 clk = ~clk;

  logic [3:0]          req_a;
  logic [FW-1:0]       fld_a [4];
  logic [3:0][AW-1:0]  add_a;
  logic [3:0]          wen_a;
  logic [3:0][DW-1:0]  wdata_a;
  logic [3:0][TW-1:0]  wtag_a;
  logic [3:0][BW-1:0]  be_a;
  logic [3:0][IW-1:0]  id_a;

  logic [2:0]          req_c;
  logic [FW-1:0]       fld_c [3];
  logic [2:0][AW-1:0]  add_c;
  logic [2:0]          wen_c;
  logic [2:0][DW-1:0]  wdata_c;
  logic [2:0][TW-1:0]  wtag_c;
  logic [2:0][BW-1:0]  be_c;
  logic [2:0][IW-1:0]  id_c;

  always_comb begin
    for (int c = 0; c < 4; c++)
      {add_a[c], wen_a[c], wdata_a[c], wtag_a[c], be_a[c], id_a[c]} = fld_a[c];
    for (int c = 0; c < 3; c++)
      {add_c[c], wen_c[c], wdata_c[c], wtag_c[c], be_c[c], id_c[c]} = fld_c[c];
  end

  logic [3:0] gnt_o0, gnt_o1;
  logic [2:0] gnt_o2;
  logic       req_o0, req_o1, req_o2;
  logic [AW-1:0] add_o0, add_o1, add_o2;
  logic          wen_o0, wen_o1, wen_o2;
  logic [DW-1:0] wdata_o0, wdata_o1, wdata_o2;
  logic [TW-1:0] wtag_o0, wtag_o1, wtag_o2;
  logic [BW-1:0] be_o0, be_o1, be_o2;
  logic [IW-1:0] id_o0, id_o1, id_o2;

  mux_n_req_l2 #(.N_CH(4), .OUT_REG(0)) u_a0 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_a), .data_add_i(add_a), .data_wen_i(wen_a),
    .data_wdata_i(wdata_a), .data_wtag_i(wtag_a), .data_be_i(be_a), .data_ID_i(id_a),
    .data_gnt_o(gnt_o0), .data_req_o(req_o0), .data_add_o(add_o0), .data_wen_o(wen_o0),
    .data_wdata_o(wdata_o0), .data_wtag_o(wtag_o0), .data_be_o(be_o0), .data_ID_o(id_o0),
    .data_gnt_i(gnt_i));

  mux_n_req_l2 #(.N_CH(4), .OUT_REG(1)) u_a1 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_a), .data_add_i(add_a), .data_wen_i(wen_a),
    .data_wdata_i(wdata_a), .data_wtag_i(wtag_a), .data_be_i(be_a), .data_ID_i(id_a),
    .data_gnt_o(gnt_o1), .data_req_o(req_o1), .data_add_o(add_o1), .data_wen_o(wen_o1),
    .data_wdata_o(wdata_o1), .data_wtag_o(wtag_o1), .data_be_o(be_o1), .data_ID_o(id_o1),
    .data_gnt_i(gnt_i));

  mux_n_req_l2 #(.N_CH(3), .OUT_REG(0)) u_c (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_c), .data_add_i(add_c), .data_wen_i(wen_c),
    .data_wdata_i(wdata_c), .data_wtag_i(wtag_c), .data_be_i(be_c), .data_ID_i(id_c),
    .data_gnt_o(gnt_o2), .data_req_o(req_o2), .data_add_o(add_o2), .data_wen_o(wen_o2),
    .data_wdata_o(wdata_o2), .data_wtag_o(wtag_o2), .data_be_o(be_o2), .data_ID_o(id_o2),
    .data_gnt_i(gnt_i));

  logic [3:0]    out_gnt [3];
  logic          out_req [3];
  logic [FW-1:0] out_fld [3];
  assign out_gnt[0] = gnt_o0;
  assign out_gnt[1] = gnt_o1;
  assign out_gnt[2] = {1'b0, gnt_o2};
  assign out_req[0] = req_o0;
  assign out_req[1] = req_o1;
  assign out_req[2] = req_o2;
  assign out_fld[0] = {add_o0, wen_o0, wdata_o0, wtag_o0, be_o0, id_o0};
  assign out_fld[1] = {add_o1, wen_o1, wdata_o1, wtag_o1, be_o1, id_o1};
  assign out_fld[2] = {add_o2, wen_o2, wdata_o2, wtag_o2, be_o2, id_o2};

  // Reference model state and expectations, one slot per instance.
  int            n_ch [3] = '{4, 4, 3};
  bit            oreg [3] = '{1'b0, 1'b1, 1'b0};
  int            mptr [3];
  bit            mbv  [3];
  logic [FW-1:0] mbuf [3];
  int            exp_w   [3];
  bit            exp_acc [3];
  logic [3:0]    exp_gnt [3];
  logic          exp_req [3];
  logic [FW-1:0] exp_fld [3];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [FW-1:0] rnd_fld();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] fld_of(int d, int c);
    return (d < 2) ? fld_a[c] : fld_c[c];
  endfunction

  // Winner = requesting channel at the smallest rotational distance from ptr.
  function automatic int winner(logic [3:0] req, int ptr, int n);
    int best = -1;
    int bd = n;
    for (int c = 0; c < n; c++) begin
      if (req[c] && ((c - ptr + n) % n) < bd) begin
        best = c;
        bd   = (c - ptr + n) % n;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mptr[d] = 0;
      mbv[d]  = 1'b0;
      mbuf[d] = '0;
    end
  endtask

  task automatic model_eval();
    logic [3:0] req;
    bit rdy;
    for (int d = 0; d < 3; d++) begin
      req = (d < 2) ? req_a : {1'b0, req_c};
      exp_w[d] = winner(req, mptr[d], n_ch[d]);
      rdy = oreg[d] ? (!mbv[d] || gnt_i) : gnt_i;
      exp_acc[d] = (exp_w[d] >= 0) && rdy && (rst_n || !oreg[d]);
      exp_gnt[d] = exp_acc[d] ? 4'(1 << exp_w[d]) : 4'b0;
      exp_req[d] = oreg[d] ? mbv[d] : |req;
      exp_fld[d] = oreg[d] ? mbuf[d] : ((exp_w[d] >= 0) ? fld_of(d, exp_w[d]) : '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int d = 0; d < 3; d++) begin
        if (exp_acc[d]) begin
          mptr[d] = (exp_w[d] + 1) % n_ch[d];
          if (oreg[d]) begin
            mbuf[d] = fld_of(d, exp_w[d]);
            mbv[d]  = 1'b1;
          end
        end else if (oreg[d] && gnt_i && mbv[d]) begin
          mbv[d] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 4'hF;
    req_c = 3'h7;
    gnt_i = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      model_eval();
      n_vec++; if (out_req[1] !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", out_req[1]); end
      n_vec++; if (out_fld[1] !== '0) begin n_err++; $display("FAIL rst_fld got %h want 0", out_fld[1]); end
      n_vec++; if (out_gnt[1] !== 4'b0) begin n_err++; $display("FAIL rst_gnt got %b want 0000", out_gnt[1]); end
      tick();
    end
    rst_n = 1'b1;
    #1;
    model_eval();
    n_vec++; if (out_gnt[1] !== 4'b0001) begin n_err++; $display("FAIL rst_first_gnt1 got %b want 0001", out_gnt[1]); end
    n_vec++; if (out_gnt[0] !== 4'b0001) begin n_err++; $display("FAIL rst_first_gnt0 got %b want 0001", out_gnt[0]); end
    tick();
  endtask

  task automatic test_rotation();
    do_reset();
    req_a = 4'hF;
    gnt_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      model_eval();
      n_vec++; if (out_gnt[0] !== 4'(1 << (i % 4))) begin n_err++; $display("FAIL rot_gnt0 i=%0d got %b want %b", i, out_gnt[0], 4'(1 << (i % 4))); end
      n_vec++; if (out_gnt[1] !== 4'(1 << (i % 4))) begin n_err++; $display("FAIL rot_gnt1 i=%0d got %b want %b", i, out_gnt[1], 4'(1 << (i % 4))); end
      n_vec++; if (out_fld[0] !== fld_a[i % 4]) begin n_err++; $display("FAIL rot_fld0 i=%0d got %h want %h", i, out_fld[0], fld_a[i % 4]); end
      n_vec++; if (out_req[1] !== (i > 0)) begin n_err++; $display("FAIL rot_req1 i=%0d got %b want %b", i, out_req[1], i > 0); end
      if (i > 0) begin
        n_vec++; if (out_fld[1] !== fld_a[(i - 1) % 4]) begin n_err++; $display("FAIL rot_fld1 i=%0d got %h want %h", i, out_fld[1], fld_a[(i - 1) % 4]); end
      end
      tick();
    end
  endtask

  task automatic test_sparse();
    int ch;
    do_reset();
    req_a = 4'b1010;
    gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ch = (i % 2 == 0) ? 1 : 3;
      #1;
      model_eval();
      n_vec++; if (out_gnt[0] !== 4'(1 << ch)) begin n_err++; $display("FAIL sparse_gnt0 i=%0d got %b want %b", i, out_gnt[0], 4'(1 << ch)); end
      n_vec++; if (out_gnt[1] !== 4'(1 << ch)) begin n_err++; $display("FAIL sparse_gnt1 i=%0d got %b want %b", i, out_gnt[1], 4'(1 << ch)); end
      tick();
    end
  endtask

  task automatic test_wrap3();
    do_reset();
    req_c = 3'b111;
    gnt_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      model_eval();
      n_vec++; if (out_gnt[2] !== 4'(1 << (i % 3))) begin n_err++; $display("FAIL wrap_gnt i=%0d got %b want %b", i, out_gnt[2], 4'(1 << (i % 3))); end
      n_vec++; if (out_fld[2] !== fld_c[i % 3]) begin n_err++; $display("FAIL wrap_fld i=%0d got %h want %h", i, out_fld[2], fld_c[i % 3]); end
      n_vec++; if (u_c.ptr_q !== 2'(i % 3)) begin n_err++; $display("FAIL wrap_ptr i=%0d got %0d want %0d", i, u_c.ptr_q, i % 3); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_a = 4'hF;
    gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      model_eval();
      tick();
    end
    gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      model_eval();
      n_vec++; if (out_req[1] !== 1'b1) begin n_err++; $display("FAIL stall_req i=%0d got %b want 1", i, out_req[1]); end
      n_vec++; if (out_fld[1] !== fld_a[2]) begin n_err++; $display("FAIL stall_fld i=%0d got %h want %h", i, out_fld[1], fld_a[2]); end
      n_vec++; if (out_gnt[1] !== 4'b0) begin n_err++; $display("FAIL stall_gnt i=%0d got %b want 0000", i, out_gnt[1]); end
      n_vec++; if (u_a1.ptr_q !== 2'd3) begin n_err++; $display("FAIL stall_ptr i=%0d got %0d want 3", i, u_a1.ptr_q); end
      tick();
    end
    gnt_i = 1'b1;
    #1;
    model_eval();
    n_vec++; if (out_gnt[1] !== 4'b1000) begin n_err++; $display("FAIL unstall_gnt got %b want 1000", out_gnt[1]); end
    tick();
    #1;
    model_eval();
    n_vec++; if (out_fld[1] !== fld_a[3]) begin n_err++; $display("FAIL unstall_fld got %h want %h", out_fld[1], fld_a[3]); end
    n_vec++; if (out_req[1] !== 1'b1) begin n_err++; $display("FAIL unstall_req got %b want 1", out_req[1]); end
    tick();
  endtask

  task automatic test_reset_stall();
    do_reset();
    req_a = 4'hF;
    gnt_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      model_eval();
      tick();
    end
    gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      model_eval();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (out_req[1] !== 1'b0) begin n_err++; $display("FAIL rststall_req got %b want 0", out_req[1]); end
    n_vec++; if (out_fld[1] !== '0) begin n_err++; $display("FAIL rststall_fld got %h want 0", out_fld[1]); end
    req_a = 4'b0110;
    gnt_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    model_eval();
    n_vec++; if (out_gnt[1] !== 4'b0010) begin n_err++; $display("FAIL rststall_gnt1 got %b want 0010", out_gnt[1]); end
    n_vec++; if (out_gnt[0] !== 4'b0010) begin n_err++; $display("FAIL rststall_gnt0 got %b want 0010", out_gnt[0]); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_a = 4'($urandom);
      req_c = 3'($urandom);
      gnt_i = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) fld_a[c] = rnd_fld();
      for (int c = 0; c < 3; c++) if ($urandom_range(0, 3) == 0) fld_c[c] = rnd_fld();
      #1;
      model_eval();
      for (int d = 0; d < 3; d++) begin
        n_vec++; if (out_gnt[d] !== exp_gnt[d]) begin n_err++; $display("FAIL rnd_gnt[%0d] i=%0d got %b want %b", d, i, out_gnt[d], exp_gnt[d]); end
        n_vec++; if (out_req[d] !== exp_req[d]) begin n_err++; $display("FAIL rnd_req[%0d] i=%0d got %b want %b", d, i, out_req[d], exp_req[d]); end
        n_vec++; if (out_fld[d] !== exp_fld[d]) begin n_err++; $display("FAIL rnd_fld[%0d] i=%0d got %h want %h", d, i, out_fld[d], exp_fld[d]); end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    gnt_i = 1'b0;
    req_a = '0;
    req_c = '0;
    for (int c = 0; c < 4; c++) fld_a[c] = rnd_fld();
    for (int c = 0; c < 3; c++) fld_c[c] = rnd_fld();
    model_reset();
    for (int d = 0; d < 3; d++) begin
      exp_w[d] = -1;
      exp_acc[d] = 1'b0;
    end
    #2;
    test_reset();
    test_rotation();
    test_sparse();
    test_wrap3();
    test_stall();
    test_reset_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
